// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with registered status and sticky errors.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   : first-word-fall-through; data_out shows the head entry
//               combinationally whenever the FIFO is not empty.
//   undefined : standard mode; data_out is registered and updates the cycle
//               after an accepted read, then holds.
//
// Parameters
//   DATA_LEN    word width
//   FIFO_DEPTH  entry count (power of two, >= 4)
//   AF_THRESH   almost_full when fill_level >= AF_THRESH
//   AE_THRESH   almost_empty when fill_level <= AE_THRESH
//
// Ports
//   clk, reset          sole clock; asynchronous active-high reset
//   write_en, data_in   push request and data
//   read_en, data_out   pop request and data
//   clear_err           clears sticky overflow/underflow
//   fifo_full, fifo_empty, almost_full, almost_empty, fill_level
//                       registered status, valid the cycle after an operation
//   overflow, underflow sticky: a write/read was rejected
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_LEN   = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    localparam int PNTR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  clear_err,
    input  logic [DATA_LEN-1:0]   data_in,
    output logic [DATA_LEN-1:0]   data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PNTR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PNTR_WIDTH:0] DEPTH_C = (PNTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [PNTR_WIDTH:0] AF_C    = (PNTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PNTR_WIDTH:0] AE_C    = (PNTR_WIDTH+1)'(AE_THRESH);

    logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable;
    // they wrap modulo 2*FIFO_DEPTH.
    logic [PNTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PNTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PNTR_WIDTH:0] fill_q,   fill_d;
    logic full_q,  full_d;
    logic empty_q, empty_d;
    logic af_q,    af_d;
    logic ae_q,    ae_d;
    logic ovf_q,   ovf_d;
    logic udf_q,   udf_d;

    logic rd_acc, wr_acc;
    logic [PNTR_WIDTH-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[PNTR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[PNTR_WIDTH-1:0];

    // A write into a full FIFO is still taken when a read frees the slot in
    // the same cycle; a read from an empty FIFO is never taken, even if a
    // write arrives alongside it.
    assign rd_acc = read_en && !empty_q;
    assign wr_acc = write_en && (!full_q || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        fill_d  = wr_ptr_d - rd_ptr_d;
        full_d  = (fill_d == DEPTH_C);
        empty_d = (fill_d == '0);
        af_d    = (fill_d >= AF_C);
        ae_d    = (fill_d <= AE_C);

        // Setting an error wins over clearing it in the same cycle.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clear_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (write_en && !wr_acc) ovf_d = 1'b1;
        if (read_en  && !rd_acc) udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_idx] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry falls through; forced to zero while empty so the output is
    // quiet out of reset.
    assign data_out = empty_q ? '0 : mem_q[rd_idx];
`else
    logic [DATA_LEN-1:0] dout_q;

    // On a simultaneous read/write at full, wr_idx == rd_idx; the
    // non-blocking write means the old (popped) word is captured here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_idx];
    end

    assign data_out = dout_q;
`endif

    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fill_level   = fill_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int DW   = 16;
    localparam int D    = 512;
    localparam int AF   = D - 4;
    localparam int AE   = 4;
    localparam int PW   = $clog2(D);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          fifo_full, fifo_empty, almost_full, almost_empty;
    logic [PW:0]   fill_level;
    logic          overflow, underflow;

    sync_fifo #(
        .DATA_LEN(DW), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .clear_err(clear_err), .data_in(data_in), .data_out(data_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus sticky flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_udf;
    int            n_pass = 0;
    int            n_total = 0;
    int            max_fill = 0;
    bit            seen_dead = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".fill"},  32'(fill_level),   32'(n));
        chk({tag, ".empty"}, 32'(fifo_empty),   32'(n == 0));
        chk({tag, ".full"},  32'(fifo_full),    32'(n == D));
        chk({tag, ".af"},    32'(almost_full),  32'(n >= AF));
        chk({tag, ".ae"},    32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
        chk({tag, ".udf"},   32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) chk({tag, ".head"}, 32'(data_out), 32'(q[0]));
`else
        chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check after.
    task automatic step(input logic we, input logic re, input logic ce,
                        input logic [DW-1:0] din, input string tag);
        bit ra, wa;
        @(negedge clk);
        write_en = we; read_en = re; clear_err = ce; data_in = din;
        ra = re && (q.size() > 0);
        wa = we && ((q.size() < D) || ra);
        @(posedge clk);
        if (ra) begin
            m_dout = q.pop_front();
            if (m_dout == 16'hDEAD) seen_dead = 1;
        end
        if (wa) q.push_back(din);
        if (ce) begin m_ovf = 0; m_udf = 0; end
        if (we && !wa) m_ovf = 1;
        if (re && !ra) m_udf = 1;
        if (q.size() > max_fill) max_fill = q.size();
        #2;
        check_all(tag);
        write_en = 0; read_en = 0; clear_err = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0; m_ovf = 0; m_udf = 0;
    endtask

    initial begin
        model_reset();
        // Reset values.
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill to full with 0..511; almost_full from fill 508.
        for (int i = 0; i < D; i++) step(1, 0, 0, DW'(i), "fill");
        chk("full_after_fill", 32'(fifo_full), 32'd1);
        step(1, 0, 0, 16'hDEAD, "push_dead");
        chk("overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < D; i++) step(0, 1, 0, '0, "drain");
        chk("dead_never_seen", 32'(seen_dead), 32'd0);
        chk("last_drained", 32'(data_out), 32'(D - 1));
        step(0, 0, 1, '0, "clr1");

        // Reads on empty: underflow, clear_err; set beats clear.
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0, "rd_empty");
        chk("underflow_set", 32'(underflow), 32'd1);
        step(0, 1, 1, '0, "set_beats_clear");
        step(0, 0, 1, '0, "clr2");
        chk("underflow_clr", 32'(underflow), 32'd0);

        // Empty with write+read: write taken, read rejected.
        step(1, 1, 0, 16'h0BEE, "empty_wr_rd");
        chk("empty_wr_rd_fill", 32'(fill_level), 32'd1);
        step(0, 1, 1, '0, "pop_bee");

        // Full with simultaneous write/read for 10 cycles.
        for (int i = 0; i < D; i++) step(1, 0, 0, DW'($urandom), "fill2");
        for (int i = 0; i < 10; i++) step(1, 1, 0, DW'(1000 + i), "full_wr_rd");
        chk("full_wr_rd_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < D; i++) step(0, 1, 0, '0, "drain2");
        chk("last_1009", 32'(data_out), 32'd1009);

        // Stream 1500 words with one-cycle read lag; pointers wrap.
        max_fill = 0;
        for (int i = 0; i <= 1500; i++) step(i < 1500, i > 0, 0, DW'(i + 7), "stream");
        chk("stream_maxfill_le2", 32'(max_fill <= 2), 32'd1);

        // Randomized traffic with shifting write/read bias.
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 55 : 45;
            for (int i = 0; i < 700; i++)
                step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
                     $urandom_range(99) < 3, DW'($urandom), "rand");
        end

        // Mid-cycle asynchronous reset after 20 pushes.
        for (int i = 0; i < 20; i++) step(1, 0, 0, DW'(300 + i), "pre_rst");
        @(negedge clk);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1 reset = 1'b0;
        step(1, 0, 0, 16'h5A5A, "post_rst_push");
        step(0, 1, 0, '0, "post_rst_pop");
        chk("post_rst_word", 32'(m_dout), 32'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        chk("timeout", 32'd1, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "FAIL timeout");
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_LEN, default 16, word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 512, entry count; power of two, >= 4.
REQ-003 Parameter AF_THRESH, default FIFO_DEPTH-4, fill level at or above which almost_full asserts.
REQ-004 Parameter AE_THRESH, default 4, fill level at or below which almost_empty asserts.
REQ-005 Derived PNTR_WIDTH = $clog2(FIFO_DEPTH).
REQ-006 One clock; reset is asynchronous and active-high: clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 write_en  in  1  push request.
REQ-009 read_en  in  1  pop request.
REQ-010 clear_err  in  1  clears sticky error flags.
REQ-011 data_in  in  DATA_LEN  push data.
REQ-012 data_out  out  DATA_LEN  pop data.
REQ-013 fifo_full  out  1  fill level == FIFO_DEPTH.
REQ-014 fifo_empty  out  1  fill level == 0.
REQ-015 almost_full  out  1  fill level >= AF_THRESH.
REQ-016 almost_empty  out  1  fill level <= AE_THRESH.
REQ-017 fill_level  out  PNTR_WIDTH+1  current entry count, 0..FIFO_DEPTH.
REQ-018 overflow  out  1  sticky: rejected write occurred.
REQ-019 underflow  out  1  sticky: rejected read occurred.

Function
REQ-020 Write and read pointers SHALL be PNTR_WIDTH+1 bit binary counters wrapping modulo 2*FIFO_DEPTH; storage index = low PNTR_WIDTH bits.
REQ-021 fill_level SHALL equal write_pointer - read_pointer (PNTR_WIDTH+1 bit modular); all status outputs registered, updated the cycle after the accepted operation.
REQ-022 Read accepted (rd_acc) when read_en && !fifo_empty; read pointer increments by 1.
REQ-023 Write accepted (wr_acc) when write_en && (!fifo_full || rd_acc); word stored at write index, pointer increments by 1.
REQ-024 Full with write_en and read_en together: both accepted, fill_level stays FIFO_DEPTH.
REQ-025 Empty with write_en and read_en together: write accepted, read rejected, underflow set, fill_level becomes 1.
REQ-026 Standard mode: data_out SHALL update one cycle after rd_acc with the popped word and hold otherwise.
REQ-027 overflow SHALL set on write_en && !wr_acc; underflow on read_en && !rd_acc; both hold until clear_err or reset; set dominates clear_err in the same cycle.
REQ-028 Rejected operations SHALL not modify pointers, storage or data_out.
REQ-029 Pointer wrap past 2*FIFO_DEPTH-1 to 0 SHALL leave fill_level and flags unaffected.

Reset
REQ-030 reset SHALL immediately set pointers to 0, fill_level 0, fifo_empty 1, almost_empty 1, fifo_full 0, almost_full 0, overflow 0, underflow 0, data_out 0.
REQ-031 Storage contents SHALL not be reset; reset mid-operation discards all entries.
REQ-032 First operation SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-033 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; data_out SHALL show the head entry combinationally from storage whenever !fifo_empty, rd_acc advances to next entry with zero-cycle latency; data_out is don't-care while empty.
REQ-034 Macro undefined: standard mode per REQ-026.

Verification
REQ-035 Reset, push 0..511 consecutive cycles -> fifo_full=1, fill_level=512, almost_full from fill 508; push 0xDEAD -> overflow=1, pops return 0..511 in order, 0xDEAD never seen.
REQ-036 Reset, read_en 5 cycles -> read pointer stays 0, fifo_empty=1, underflow=1; clear_err pulse -> underflow=0.
REQ-037 Full FIFO, write_en and read_en 10 cycles with data 1000..1009 -> fill_level 512 throughout, overflow=0, all pushed words later read in order.
REQ-038 Stream 1500 words with 1-cycle read lag -> pointers wrap twice, every word matches, fill_level <= 2.
REQ-039 Push 20 words, reset asserted mid-cycle between edges -> outputs reach reset values before next clk edge; next push/pop returns the new word.
REQ-040 SYNC_FIFO_FWFT_EN build, push 0x1234 -> data_out=0x1234 cycle after push with no read_en; pop -> fifo_empty=1.
